// File: rtl/bus16_pkg.sv
// bus16_pkg: shared register indices and constants for the 16-bit bus register bank
package bus16_pkg;
  localparam int REG_ID = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_IRQ_MASK = 2;
  localparam int REG_CTRL0 = 3;
  localparam logic [15:0] RD_ERR_DATA = 16'hDEAD;
  localparam logic [15:0] DEFAULT_ID = 16'hB516;
endpackage

// File: rtl/bus16_reg_bank_if.sv
// bus16_reg_bank_if: bridge-to-register-bank bus; master is the UART bridge, slave the bank
interface bus16_reg_bank_if;
  logic bus_cs;
  logic bus_wr_rd_n;
  logic [15:0] bus_addr8;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;
  logic bus_rd_dv;
  logic bus_err;
  modport master (
    output bus_cs, bus_wr_rd_n, bus_addr8, bus_wr_data,
    input bus_rd_data, bus_rd_dv, bus_err
  );
  modport slave (
    input bus_cs, bus_wr_rd_n, bus_addr8, bus_wr_data,
    output bus_rd_data, bus_rd_dv, bus_err
  );
endinterface

// File: rtl/bus16_rd_pipe.sv
// bus16_rd_pipe: DEPTH-stage valid/data delay line; data stages hold 0 when not valid
module bus16_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int W = 16
) (
  input logic i_Bus_Rst_L,
  input logic i_Bus_Clk,
  input logic in_valid,
  input logic [W-1:0] in_data,
  output logic out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0][W-1:0] d;
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L)
    if (!i_Bus_Rst_L) begin
      v <= '0;
      d <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_valid ? in_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        d[k] <= d[k-1];
      end
    end
  assign out_valid = v[DEPTH-1];
  assign out_data = d[DEPTH-1];
endmodule

// File: rtl/bus16_reg_bank.sv
// bus16_reg_bank: register-bank bus slave (ID, sticky STATUS, IRQ_MASK, CTRL regs)
// REGBANK_STATUS_W1C_EN makes STATUS write-1-to-clear; otherwise STATUS is read-to-clear.
module bus16_reg_bank
  import bus16_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int RD_LATENCY = 2,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ID_VALUE = DEFAULT_ID
) (
  input logic i_Bus_Rst_L,
  input logic i_Bus_Clk,
  bus16_reg_bank_if.slave bus,
  input logic [15:0] i_Status_Set,
  output logic [NUM_REGS*16-1:0] o_Ctrl_Regs,
  output logic [NUM_REGS-1:0] o_Wr_Strobe,
  output logic o_Irq
);
  localparam int IW = $clog2(NUM_REGS);
  logic cs_q, accept, legal, wr_hit, rd_acc, pipe_dv;
  logic [15:0] offset, status_q, status_clr, rd_val, pipe_data;
  logic [IW-1:0] idx;
  logic [NUM_REGS-1:0][15:0] regs;
  logic [NUM_REGS-1:2][15:0] rw_q;
  assign accept = bus.bus_cs & ~cs_q;
  assign offset = bus.bus_addr8 - BASE_ADDR;
  assign legal = ~offset[0] && offset < 16'(2 * NUM_REGS);
  assign idx = offset[IW:1];
  assign wr_hit = accept & bus.bus_wr_rd_n & legal;
  assign rd_acc = accept & ~bus.bus_wr_rd_n;
  assign rd_val = legal ? regs[idx] : RD_ERR_DATA;
`ifdef REGBANK_STATUS_W1C_EN
  assign status_clr = (wr_hit && idx == IW'(REG_STATUS)) ? bus.bus_wr_data : '0;
`else
  assign status_clr = (rd_acc && legal && idx == IW'(REG_STATUS)) ? '1 : '0;
`endif
  always_comb begin
    regs[REG_ID] = ID_VALUE;
    regs[REG_STATUS] = status_q;
    for (int k = REG_IRQ_MASK; k < NUM_REGS; k++) regs[k] = rw_q[k];
  end
  // set beats clear: the new events are OR-ed in after the clear mask
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L)
    if (!i_Bus_Rst_L) begin
      cs_q <= 1'b0;
      status_q <= '0;
      rw_q <= '0;
      o_Wr_Strobe <= '0;
      o_Irq <= 1'b0;
      bus.bus_err <= 1'b0;
    end else begin
      cs_q <= bus.bus_cs;
      status_q <= (status_q & ~status_clr) | i_Status_Set;
      for (int k = REG_IRQ_MASK; k < NUM_REGS; k++)
        if (wr_hit && idx == IW'(k)) rw_q[k] <= bus.bus_wr_data;
      o_Wr_Strobe <= wr_hit ? NUM_REGS'(1) << idx : '0;
      o_Irq <= |(status_q & rw_q[REG_IRQ_MASK]);
      bus.bus_err <= accept & ~legal;
    end
  bus16_rd_pipe #(.DEPTH(RD_LATENCY), .W(16)) u_rd_pipe (
    .i_Bus_Rst_L(i_Bus_Rst_L),
    .i_Bus_Clk(i_Bus_Clk),
    .in_valid(rd_acc),
    .in_data(rd_val),
    .out_valid(pipe_dv),
    .out_data(pipe_data)
  );
  assign bus.bus_rd_dv = pipe_dv;
  assign bus.bus_rd_data = pipe_data;
  assign o_Ctrl_Regs = regs;
endmodule

// File: tb/tb_bus16_reg_bank.sv
// tb_bus16_reg_bank: vector table plus read scoreboard for bus16_reg_bank
module tb_bus16_reg_bank;
  import bus16_pkg::*;
  localparam int N = 8;
  localparam int LAT = 2;
  localparam int NV = 18;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic [15:0] status_set;
  logic [N*16-1:0] ctrl, exp_ctrl;
  logic [N-1:0] strb;
  logic irq;
  int checks = 0, errors = 0, cyc = 0, dv_cnt = 0, dv_mark;
  typedef struct {logic [15:0] data; int due;} exp_t;
  typedef struct {logic wr; logic [15:0] addr, data, exp; logic err; logic [N-1:0] strb;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[NV];
  bus16_reg_bank_if bus();
  bus16_reg_bank dut (
    .i_Bus_Rst_L(rst_l),
    .i_Bus_Clk(clk),
    .bus(bus),
    .i_Status_Set(status_set),
    .o_Ctrl_Regs(ctrl),
    .o_Wr_Strobe(strb),
    .o_Irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // every read is expected exactly LAT cycles after its drive cycle
  always @(negedge clk)
    if (rst_l) begin
      if (bus.bus_rd_dv) begin
        dv_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dv: got data %h at cycle %0d, expected no DV", bus.bus_rd_data, cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("rd_data_cycle@%0d", e.due), {bus.bus_rd_data, 32'(cyc)}, {e.data, 32'(e.due)});
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk($sformatf("missing_dv@%0d", e.due), 1'b0, 1'b1);
      end
    end
  task automatic access(input logic wr, input logic [15:0] addr, data, exp,
                        input logic err, input logic [N-1:0] st);
    @(posedge clk); #1;
    bus.bus_cs = 1'b1;
    bus.bus_wr_rd_n = wr;
    bus.bus_addr8 = addr;
    bus.bus_wr_data = data;
    if (!wr) sb.push_back('{exp, cyc + LAT});
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("err@%h", addr), bus.bus_err, err);
    chk($sformatf("strobe@%h", addr), strb, st);
    bus.bus_cs = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.bus_cs = 1'b0;
    bus.bus_wr_rd_n = 1'b0;
    bus.bus_addr8 = '0;
    bus.bus_wr_data = '0;
    status_set = '0;
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 16'hB516, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 16'h0006, 16'h1234, 16'h0000, 1'b0, 8'h08};
    vecs[2] = '{1'b0, 16'h0006, 16'h0000, 16'h1234, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 16'h000E, 16'hABCD, 16'h0000, 1'b0, 8'h80};
    vecs[4] = '{1'b0, 16'h000E, 16'h0000, 16'hABCD, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 16'h0003, 16'h0000, 16'hDEAD, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 16'h0010, 16'h0000, 16'hDEAD, 1'b1, 8'h00};
    vecs[7] = '{1'b1, 16'h0003, 16'hFFFF, 16'h0000, 1'b1, 8'h00};
    vecs[8] = '{1'b1, 16'h0010, 16'hFFFF, 16'h0000, 1'b1, 8'h00};
    vecs[9] = '{1'b1, 16'h0016, 16'hFFFF, 16'h0000, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 16'h0006, 16'h0000, 16'h1234, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 16'h0000, 16'h5555, 16'h0000, 1'b0, 8'h01};
    vecs[13] = '{1'b0, 16'h0000, 16'h0000, 16'hB516, 1'b0, 8'h00};
    vecs[14] = '{1'b1, 16'h0004, 16'h00F0, 16'h0000, 1'b0, 8'h04};
    vecs[15] = '{1'b0, 16'h0004, 16'h0000, 16'h00F0, 1'b0, 8'h00};
    vecs[16] = '{1'b0, 16'hFFFE, 16'h0000, 16'hDEAD, 1'b1, 8'h00};
    vecs[17] = '{1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0, 8'h04};
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_ctrl = '0;
    exp_ctrl[15:0] = 16'hB516;
    chk("reset_dv", bus.bus_rd_dv, 1'b0);
    chk("reset_err", bus.bus_err, 1'b0);
    chk("reset_rd_data", bus.bus_rd_data, 16'h0000);
    chk("reset_strobe", strb, '0);
    chk("reset_irq", irq, 1'b0);
    chk("reset_ctrl", ctrl, exp_ctrl);
    rst_l = 1'b1;
    for (int i = 0; i < NV; i++)
      access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, vecs[i].err, vecs[i].strb);
    @(negedge clk);
    chk("strobe_one_pulse", strb, '0);
    chk("ctrl3", ctrl[63:48], 16'h1234);
    chk("ctrl7", ctrl[127:112], 16'hABCD);
    chk("ctrl_id", ctrl[15:0], 16'hB516);
    @(posedge clk); #1 status_set = 16'h0005;
    @(posedge clk); #1 status_set = 16'h0000;
    access(1'b1, 16'h0004, 16'h0004, 16'h0000, 1'b0, 8'h04);
    @(posedge clk);
    @(negedge clk);
    chk("irq_set", irq, 1'b1);
    chk("status_5", ctrl[31:16], 16'h0005);
`ifdef REGBANK_STATUS_W1C_EN
    access(1'b1, 16'h0002, 16'h0004, 16'h0000, 1'b0, 8'h02);
    @(posedge clk);
    @(negedge clk);
    chk("w1c_status", ctrl[31:16], 16'h0001);
    chk("w1c_irq", irq, 1'b0);
    status_set = 16'h0001;
    access(1'b1, 16'h0002, 16'h0001, 16'h0000, 1'b0, 8'h02);
    status_set = 16'h0000;
    chk("set_beats_clear", ctrl[31:16], 16'h0001);
    access(1'b0, 16'h0002, 16'h0000, 16'h0001, 1'b0, 8'h00);
    @(negedge clk);
    chk("w1c_read_keeps", ctrl[31:16], 16'h0001);
`else
    access(1'b0, 16'h0002, 16'h0000, 16'h0005, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("r2c_status", ctrl[31:16], 16'h0000);
    chk("r2c_irq", irq, 1'b0);
    status_set = 16'h0001;
    access(1'b0, 16'h0002, 16'h0000, 16'h0001, 1'b0, 8'h00);
    status_set = 16'h0000;
    chk("set_beats_clear", ctrl[31:16], 16'h0001);
    access(1'b1, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, 8'h02);
    @(negedge clk);
    chk("r2c_write_ignored", ctrl[31:16], 16'h0001);
`endif
    @(posedge clk); #1;
    bus.bus_cs = 1'b1;
    bus.bus_wr_rd_n = 1'b0;
    bus.bus_addr8 = 16'h0006;
    sb.push_back('{16'h1234, cyc + LAT});
    repeat (5) @(posedge clk);
    #1 bus.bus_cs = 1'b0;
    @(posedge clk); #1;
    bus.bus_cs = 1'b1;
    bus.bus_addr8 = 16'h0000;
    sb.push_back('{16'hB516, cyc + LAT});
    @(posedge clk); #1 bus.bus_cs = 1'b0;
    @(posedge clk); #1;
    bus.bus_cs = 1'b1;
    bus.bus_addr8 = 16'h000E;
    sb.push_back('{16'hABCD, cyc + LAT});
    @(posedge clk); #1 bus.bus_cs = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("burst_drained", sb.size(), 0);
    @(posedge clk); #1;
    bus.bus_cs = 1'b1;
    bus.bus_addr8 = 16'h0000;
    @(posedge clk); #2;
    rst_l = 1'b0;
    bus.bus_cs = 1'b0;
    dv_mark = dv_cnt;
    #1 chk("dv_in_reset", bus.bus_rd_dv, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_dv_after_reset", dv_cnt, dv_mark);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
